// File: rtl/display_mem_writer.sv
// display_mem_writer: arbitrates BPM/ECG/EMG updates into the shared display RAM.
// Sweep mode by default; defining SCROLL_EN selects the scrolling window mode.
module display_mem_writer #(
    parameter logic [11:0] ECG_BASE = 12'h559,
    parameter logic [11:0] EMG_BASE = 12'h6AD,
    parameter logic [11:0] BPM_ADDR = 12'd1704,
    parameter int          DEPTH    = 320,
    parameter int          BPM_MAX  = 999
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ecg_valid,
    input  logic [11:0] ecg_data,
    output logic        ecg_ready,
    input  logic        emg_valid,
    input  logic [11:0] emg_data,
    output logic        emg_ready,
    input  logic        bpm_valid,
    input  logic [9:0]  bpm_value,
    output logic        bpm_ready,
    output logic        mem_we,
    output logic [11:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [11:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WRITE, SHIFT_RD, SHIFT_WR} state_t;
    localparam logic [11:0] LAST    = 12'(DEPTH - 1);
    localparam logic [9:0]  BPM_SAT = 10'(BPM_MAX);

    state_t      state, state_next;
    logic        bpm_go, ecg_go, emg_go, last_pair;
    logic [11:0] go_base, go_data;
    logic [9:0]  bpm_sat;
    logic [11:0] waddr_q;
    logic [31:0] wdata_q;

    assign bpm_go  = bpm_valid && bpm_ready;
    assign ecg_go  = ecg_valid && ecg_ready;
    assign emg_go  = emg_valid && emg_ready;
    assign go_base = ecg_go ? ECG_BASE : EMG_BASE;
    assign go_data = ecg_go ? ecg_data : emg_data;
    assign bpm_sat = bpm_value > BPM_SAT ? BPM_SAT : bpm_value;

`ifdef SCROLL_EN
    localparam state_t SAMPLE_ST = SHIFT_RD;
    logic        ch_q;
    logic [11:0] sample_q, idx_q, raddr_q, base;
    assign base      = ch_q ? EMG_BASE : ECG_BASE;
    assign last_pair = idx_q == LAST - 12'd1;
    assign mem_raddr = raddr_q;
`else
    localparam state_t SAMPLE_ST = WRITE;
    logic [11:0] wp_ecg, wp_emg;
    assign last_pair = 1'b1;
    assign mem_raddr = '0;
`endif

    always_ff @(posedge clock)
        state <= reset ? IDLE : state_next;

    always_comb begin
        state_next = bpm_go ? WRITE :
                     (ecg_go || emg_go) ? SAMPLE_ST :
                     state == WRITE ? IDLE :
                     state == SHIFT_RD ? SHIFT_WR :
                     state == SHIFT_WR ? (last_pair ? WRITE : SHIFT_RD) : state;
    end

    // Reset gates the strobes combinationally so an aborted sweep never writes again.
    always_comb begin
        bpm_ready = state == IDLE && !reset;
        ecg_ready = bpm_ready && !bpm_valid;
        emg_ready = ecg_ready && !ecg_valid;
        mem_we    = !reset && (state == WRITE || state == SHIFT_WR);
        busy      = state != IDLE;
        mem_waddr = waddr_q;
        mem_wdata = state == SHIFT_WR ? mem_rdata : wdata_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            waddr_q <= '0;
            wdata_q <= '0;
`ifdef SCROLL_EN
            ch_q     <= 1'b0;
            sample_q <= '0;
            idx_q    <= '0;
            raddr_q  <= '0;
`else
            wp_ecg <= '0;
            wp_emg <= '0;
`endif
        end else if (bpm_go) begin
            waddr_q <= BPM_ADDR;
            wdata_q <= {22'b0, bpm_sat};
        end else if (ecg_go || emg_go) begin
`ifdef SCROLL_EN
            ch_q     <= emg_go;
            sample_q <= go_data;
            idx_q    <= '0;
            raddr_q  <= go_base + 12'd1;
`else
            waddr_q <= go_base + (ecg_go ? wp_ecg : wp_emg);
            wdata_q <= {20'b0, go_data};
            if (ecg_go)
                wp_ecg <= wp_ecg == LAST ? 12'd0 : wp_ecg + 12'd1;
            else
                wp_emg <= wp_emg == LAST ? 12'd0 : wp_emg + 12'd1;
`endif
        end
`ifdef SCROLL_EN
        else if (state == SHIFT_RD)
            waddr_q <= base + idx_q;
        else if (state == SHIFT_WR) begin
            // wdata_q tracks the word just shifted so mem_wdata holds between writes
            if (last_pair) begin
                waddr_q <= base + LAST;
                wdata_q <= {20'b0, sample_q};
            end else begin
                wdata_q <= mem_rdata;
                idx_q   <= idx_q + 12'd1;
                raddr_q <= base + idx_q + 12'd2;
            end
        end
`endif
    end
endmodule

// File: doc/display_mem_writer.md
# display_mem_writer

Write-side companion of the VGA display path: accepts ECG samples, EMG samples and BPM values from the processing side through valid/ready handshakes and writes them into the shared display memory that the VGA scan-out reads. Each trace occupies a linear window of DEPTH words, and the BPM occupies one word. Sits between the signal-processing pipeline and the display RAM's write port, with a read port used for scrolling.

## Interface
- ECG_BASE, 12'h559, first word of the ECG trace window
- EMG_BASE, 12'h6AD, first word of the EMG trace window
- BPM_ADDR, 12'd1704, word holding the binary BPM value
- DEPTH, 320, samples per trace window (≥2)
- BPM_MAX, 999, BPM saturation limit

Ports:
- clock  in  1  system clock; reset reset, synchronous, active-high; clock clock
- reset  in  1  synchronous, active-high
- ecg_valid / ecg_data / ecg_ready  in / in / out  1 / 12 / 1  ECG sample handshake
- emg_valid / emg_data / emg_ready  in / in / out  1 / 12 / 1  EMG sample handshake
- bpm_valid / bpm_value / bpm_ready  in / in / out  1 / 10 / 1  BPM update handshake
- mem_we  out  1  write strobe, one word per cycle
- mem_waddr  out  12  write address
- mem_wdata  out  32  write data
- mem_raddr  out  12  read address (scroll mode only)
- mem_rdata  in  32  read data, valid one cycle after mem_raddr
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, WRITE, SHIFT_RD, SHIFT_WR. One transfer is serviced at a time.
- Readies are combinational: x_ready = (state==IDLE) && no higher-priority valid. Priority: BPM > ECG > EMG. Transfer = valid && ready. Loser's valid must stay high; its data is sampled only on its own transfer.
- BPM transfer: latch min(bpm_value, BPM_MAX), zero-extended to 32 bits -> WRITE at BPM_ADDR.
- Sample transfer: data zero-extended to 32 bits (bits [11:0]); the VGA plots bits [11:4].
- Sweep mode (macro absent): each channel has a write pointer wp (0..DEPTH-1). WRITE at base+wp, then wp = (wp==DEPTH-1) ? 0 : wp+1. Wrap-around is silent.
- Scroll mode (macro present): for i = 0..DEPTH-2, SHIFT_RD drives mem_raddr = base+i+1, then SHIFT_WR writes mem_rdata to base+i. Afterwards WRITE stores the new sample at base+DEPTH-1. The newest sample is always rightmost, and the oldest is discarded.
- WRITE returns to IDLE.
- Address arithmetic is 12-bit. The windows must not overlap (integrator responsibility, not checked).

## Timing
- Reset values: mem_we=0, mem_waddr=0, mem_wdata=0, mem_raddr=0, busy=0, state IDLE, both wp=0.
- Readies are 0 while reset is asserted and may assert in the first cycle after release.
- Transfer in cycle T: mem_we is high for exactly one cycle, and the write lands in that cycle.
- Sweep and BPM: mem_we=1 in T+1; IDLE with ready available in T+2 (2-cycle throughput).
- Scroll sample: SHIFT pairs occupy T+1 .. T+2(DEPTH-1). The final WRITE is in T+2(DEPTH-1)+1, and IDLE follows. DEPTH=320 gives 640 cycles per sample.
- mem_we=0 in SHIFT_RD and IDLE. mem_waddr and mem_wdata hold their last values when mem_we=0.
- Reset mid-operation aborts immediately: no further writes, pointers cleared, and a partially shifted window is left as is.
- Simultaneous valids: exactly one ready is high. The others wait and are served on subsequent IDLE cycles in priority order.

## Configuration
- SCROLL_EN defined: scroll mode as above; mem_raddr is active.
- SCROLL_EN undefined: sweep mode; wp registers exist, mem_raddr is tied to 0, and SHIFT states are never entered.

## Test plan
- Reset, then bpm_value=72 -> one write: addr 1704, data 32'd72, busy back to 0 two cycles after the transfer.
- bpm_value=1020 -> data 32'd999 written to 1704.
- Sweep: 321 ECG samples 0..320 -> writes at 0x559+0..0x559+319, then sample 320 at 0x559 (wrap); EMG pointer still 0.
- ECG, EMG and BPM valid in the same cycle -> service order BPM, ECG, EMG; only one ready high per cycle; each value is written exactly once.
- Scroll with memory model preloaded base+i = i -> after sample 12'hABC, base+i = i+1 for i<319 and base+319 = 12'hABC; IDLE exactly 640 cycles after the transfer.
- Scroll: reset asserted 100 cycles into the shift -> mem_we low from the next cycle; after release, a new BPM transfer completes normally.
